// File: rtl/output_frame_formatter.sv
// Output frame formatter: tags each incoming pixel byte with raster
// coordinates and frame markers, buffers it in a first-word-fall-through
// FIFO, and presents it to the output port. It also flags dropped bytes
// and frames of the wrong length, and pulses FrameDone once a frame has
// fully drained.
//
// Handshake: PixelValid is high whenever the FIFO holds at least one entry,
// and the head fields are stable while it stays high. A pixel transfers on
// every rising clock edge where PixelValid && PixelReady. PixelReady may
// depend on PixelValid. The upstream side has no ready signal, so a byte
// offered while the FIFO is full and nothing pops is dropped.
module output_frame_formatter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DEPTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              DataIn,
    input  logic                    StartIn,
    input  logic                    DoneIn,
    output logic [7:0]              PixelOut,
    output logic [9:0]              PixelX,
    output logic [8:0]              PixelY,
    output logic                    SOF,
    output logic                    EOL,
    output logic                    EOF,
    output logic                    PixelValid,
    input  logic                    PixelReady,
    output logic [$clog2(DEPTH):0]  Level,
    output logic                    Overflow,
    output logic                    FrameError,
    output logic                    FrameDone,
    output logic [1:0]              fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [9:0]  X_LAST     = 10'(WIDTH - 1);
    localparam logic [8:0]  Y_LAST     = 9'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t state;

    // Entry layout: {data[29:22], x[21:12], y[11:3], sof, eol, eof}
    logic [29:0]   mem [DEPTH];
    logic [29:0]   head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [AW:0]   level_next;
    logic [9:0]    wx;
    logic [8:0]    wy;

    logic accept;
    logic full;
    logic pop;
    logic push;
    logic w_sof;
    logic w_eol;
    logic w_eof;

    // Write-side decisions, FIFO handshake and next occupancy
    always_comb begin
        accept     = StartIn && (state == IDLE || state == STREAM);
        full       = (level == FULL_LEVEL);
        pop        = (level != '0) && PixelReady;
        // A full FIFO still accepts a byte when the head leaves in the same cycle
        push       = accept && (!full || pop);
        w_sof      = (wx == '0) && (wy == '0);
        w_eol      = (wx == X_LAST);
        w_eof      = w_eol && (wy == Y_LAST);
        level_next = level;
        if (push && !pop) begin
            level_next = level + 1'b1;
        end else if (pop && !push) begin
            level_next = level - 1'b1;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {DataIn, wx, wy, w_sof, w_eol, w_eof};
        end
    end

    // Pointers, occupancy, write counters, frame FSM and sticky flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            wx         <= '0;
            wy         <= '0;
            Overflow   <= 1'b0;
            FrameError <= 1'b0;
            FrameDone  <= 1'b0;
        end else begin
            FrameDone <= 1'b0;
            level     <= level_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && full && !pop) begin
                Overflow <= 1'b1;
            end
            // Dropped bytes still advance the counters so coordinates track the image
            if (accept) begin
                if (w_eol) begin
                    wx <= '0;
                    wy <= w_eof ? '0 : wy + 1'b1;
                end else begin
                    wx <= wx + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= w_eof ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    if (accept && w_eof) begin
                        state <= DRAIN;
                    end else if (DoneIn) begin
                        FrameError <= 1'b1;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (StartIn) begin
                        FrameError <= 1'b1;
                    end
                    // Done is raised together with the final pop so it shows the cycle after
                    if (level_next == '0) begin
                        state     <= IDLE;
                        FrameDone <= 1'b1;
                        wx        <= '0;
                        wy        <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Head entry presented on the output port, forced to zero while empty
    always_comb begin
        head       = mem[rd_ptr];
        PixelValid = (level != '0);
        PixelOut   = '0;
        PixelX     = '0;
        PixelY     = '0;
        SOF        = 1'b0;
        EOL        = 1'b0;
        EOF        = 1'b0;
        if (PixelValid) begin
            PixelOut = head[29:22];
            PixelX   = head[21:12];
            PixelY   = head[11:3];
            SOF      = head[2];
            EOL      = head[1];
            EOF      = head[0];
        end
    end

    assign Level     = level;
    assign fsm_state = state;

endmodule

// File: tb/tb_output_frame_formatter.sv
// Directed bench for output_frame_formatter. Instance a is a 4x2 frame
// and covers clean, gapped, short and long frames. Instance b is an 8x4
// frame, large enough to fill the 16-entry FIFO within one frame, and
// covers backpressure, overflow and push/pop at full.
module tb_output_frame_formatter;

    logic       clock;
    int         n_checks = 0;
    int         n_pass   = 0;

    logic       a_reset, a_start, a_done_in, a_ready;
    logic [7:0] a_data;
    logic [7:0] a_pix;
    logic [9:0] a_x;
    logic [8:0] a_y;
    logic       a_sof, a_eol, a_eof, a_valid, a_ovf, a_ferr, a_fdone;
    logic [4:0] a_level;
    logic [1:0] a_state;

    logic       b_reset, b_start, b_done_in, b_ready;
    logic [7:0] b_data;
    logic [7:0] b_pix;
    logic [9:0] b_x;
    logic [8:0] b_y;
    logic       b_sof, b_eol, b_eof, b_valid, b_ovf, b_ferr, b_fdone;
    logic [4:0] b_level;
    logic [1:0] b_state;

    // Expected raster tags for a 4x2 frame, pixel order 0..7
    int clean_x   [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int clean_y   [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int clean_sof [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    int clean_eol [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int clean_eof [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    output_frame_formatter #(.WIDTH(4), .HEIGHT(2), .DEPTH(16)) dut_a (
        .clock(clock), .reset(a_reset), .DataIn(a_data), .StartIn(a_start),
        .DoneIn(a_done_in), .PixelOut(a_pix), .PixelX(a_x), .PixelY(a_y),
        .SOF(a_sof), .EOL(a_eol), .EOF(a_eof), .PixelValid(a_valid),
        .PixelReady(a_ready), .Level(a_level), .Overflow(a_ovf),
        .FrameError(a_ferr), .FrameDone(a_fdone), .fsm_state(a_state)
    );

    output_frame_formatter #(.WIDTH(8), .HEIGHT(4), .DEPTH(16)) dut_b (
        .clock(clock), .reset(b_reset), .DataIn(b_data), .StartIn(b_start),
        .DoneIn(b_done_in), .PixelOut(b_pix), .PixelX(b_x), .PixelY(b_y),
        .SOF(b_sof), .EOL(b_eol), .EOF(b_eof), .PixelValid(b_valid),
        .PixelReady(b_ready), .Level(b_level), .Overflow(b_ovf),
        .FrameError(b_ferr), .FrameDone(b_fdone), .fsm_state(b_state)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_a(input logic [7:0] d);
        a_start = 1'b1;
        a_data  = d;
        tick();
        a_start = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        b_start = 1'b1;
        b_data  = d;
        tick();
        b_start = 1'b0;
    endtask

    task automatic head_a(input string tag, input int d, input int x, input int y,
                          input int sof, input int eol, input int eof);
        check({tag, "_valid"}, 32'(a_valid), 1);
        check({tag, "_data"},  32'(a_pix), d);
        check({tag, "_x"},     32'(a_x), x);
        check({tag, "_y"},     32'(a_y), y);
        check({tag, "_sof"},   32'(a_sof), sof);
        check({tag, "_eol"},   32'(a_eol), eol);
        check({tag, "_eof"},   32'(a_eof), eof);
    endtask

    task automatic head_b(input string tag, input int d, input int x, input int y,
                          input int sof, input int eol, input int eof);
        check({tag, "_valid"}, 32'(b_valid), 1);
        check({tag, "_data"},  32'(b_pix), d);
        check({tag, "_x"},     32'(b_x), x);
        check({tag, "_y"},     32'(b_y), y);
        check({tag, "_sof"},   32'(b_sof), sof);
        check({tag, "_eol"},   32'(b_eol), eol);
        check({tag, "_eof"},   32'(b_eof), eof);
    endtask

    initial begin
        a_reset = 1'b1; a_start = 1'b0; a_done_in = 1'b0; a_ready = 1'b0; a_data = '0;
        b_reset = 1'b1; b_start = 1'b0; b_done_in = 1'b0; b_ready = 1'b0; b_data = '0;
        tick();
        tick();

        // Reset state of both instances
        check("rst_a_level", 32'(a_level), 0);
        check("rst_a_valid", 32'(a_valid), 0);
        check("rst_a_ovf",   32'(a_ovf), 0);
        check("rst_a_ferr",  32'(a_ferr), 0);
        check("rst_a_done",  32'(a_fdone), 0);
        check("rst_a_state", 32'(a_state), 0);
        check("rst_b_level", 32'(b_level), 0);
        check("rst_b_valid", 32'(b_valid), 0);
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Clean frame: 8 back-to-back bytes, consumer always ready
        a_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_a(8'h10 + 8'(i));
            head_a($sformatf("clean%0d", i), 'h10 + i, clean_x[i], clean_y[i],
                   clean_sof[i], clean_eol[i], clean_eof[i]);
            check($sformatf("clean%0d_level", i), 32'(a_level), 1);
        end
        check("clean_state_drain", 32'(a_state), 2);
        check("clean_done_early", 32'(a_fdone), 0);
        tick();
        check("clean_done", 32'(a_fdone), 1);
        check("clean_level0", 32'(a_level), 0);
        check("clean_idle", 32'(a_state), 0);
        tick();
        check("clean_done_one_cycle", 32'(a_fdone), 0);
        check("clean_ovf", 32'(a_ovf), 0);
        check("clean_ferr", 32'(a_ferr), 0);

        // Gapped frame: one idle cycle after every byte
        for (int i = 0; i < 8; i++) begin
            push_a(8'hA0 + 8'(i));
            head_a($sformatf("gap%0d", i), 'hA0 + i, clean_x[i], clean_y[i],
                   clean_sof[i], clean_eol[i], clean_eof[i]);
            tick();
            check($sformatf("gap%0d_empty", i), 32'(a_valid), 0);
        end
        check("gap_done", 32'(a_fdone), 1);
        check("gap_ferr", 32'(a_ferr), 0);

        // Short frame: 5 bytes held in the FIFO, then DoneIn
        a_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_a(8'h20 + 8'(i));
        end
        check("short_level", 32'(a_level), 5);
        a_done_in = 1'b1;
        tick();
        a_done_in = 1'b0;
        check("short_ferr", 32'(a_ferr), 1);
        check("short_state_drain", 32'(a_state), 2);
        a_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("short_drain%0d", k), 32'(a_pix), 'h20 + k);
            check($sformatf("short_nodone%0d", k), 32'(a_fdone), 0);
            tick();
        end
        check("short_done", 32'(a_fdone), 1);
        check("short_idle", 32'(a_state), 0);
        check("short_level0", 32'(a_level), 0);

        // Clear the sticky error before the long-frame case
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        check("rst_ferr_cleared", 32'(a_ferr), 0);

        // Long frame: a 9th byte right after the final pixel is discarded
        for (int i = 0; i < 8; i++) begin
            push_a(8'h70 + 8'(i));
        end
        check("long_ferr_before", 32'(a_ferr), 0);
        head_a("long_last", 'h77, 3, 1, 0, 1, 1);
        push_a(8'h99);
        check("long_ferr", 32'(a_ferr), 1);
        check("long_done", 32'(a_fdone), 1);
        check("long_level0", 32'(a_level), 0);
        tick();
        check("long_byte_dropped", 32'(a_valid), 0);
        check("long_idle", 32'(a_state), 0);

        // Simultaneous push and pop while full
        b_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_b(8'h30 + 8'(i));
        end
        check("full_level", 32'(b_level), 16);
        b_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            push_b(8'h40 + 8'(j));
            check($sformatf("full_pp%0d_level", j), 32'(b_level), 16);
            check($sformatf("full_pp%0d_ovf", j), 32'(b_ovf), 0);
        end
        head_b("full_head", 'h35, 5, 0, 0, 0, 0);

        b_reset = 1'b1;
        tick();
        b_reset = 1'b0;

        // Backpressure: fill the FIFO, then two bytes arrive and are dropped
        b_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_b(8'h40 + 8'(i));
        end
        check("bp_level16", 32'(b_level), 16);
        check("bp_ovf_before", 32'(b_ovf), 0);
        push_b(8'h50);
        push_b(8'h51);
        check("bp_level_held", 32'(b_level), 16);
        check("bp_ovf", 32'(b_ovf), 1);
        head_b("bp_head0", 'h40, 0, 0, 1, 0, 0);
        b_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 15) begin
                head_b("bp_head15", 'h4F, 7, 1, 0, 1, 0);
            end
            check($sformatf("bp_pop%0d", k), 32'(b_pix), 'h40 + k);
            tick();
        end
        check("bp_empty", 32'(b_level), 0);
        push_b(8'h60);
        head_b("bp_idx18", 'h60, 2, 2, 0, 0, 0);
        tick();
        check("bp_ovf_sticky", 32'(b_ovf), 1);

        // Reset while three pixels are buffered and both sticky flags are up
        a_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_a(8'h01 + 8'(i));
        end
        check("mid_level3", 32'(a_level), 3);
        check("mid_ferr_sticky", 32'(a_ferr), 1);
        a_reset = 1'b1;
        b_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        b_reset = 1'b0;
        check("mid_rst_level", 32'(a_level), 0);
        check("mid_rst_valid", 32'(a_valid), 0);
        check("mid_rst_ferr",  32'(a_ferr), 0);
        check("mid_rst_ovf",   32'(a_ovf), 0);
        check("mid_rst_b_ovf", 32'(b_ovf), 0);
        check("mid_rst_b_lvl", 32'(b_level), 0);
        check("mid_rst_state", 32'(a_state), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
